// File: rtl/csp_pkg.sv
// Shared types and helpers for the CSP rendezvous channel.
//   chan_state_t : rendezvous FSM state encoding
//   to_p1of4     : 2-bit value -> 1-of-4 one-hot code
package csp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SND_WAIT = 2'd1,
        RCV_WAIT = 2'd2,
        DONE     = 2'd3
    } chan_state_t;

    // One-hot code with the set bit at the position given by the value.
    function automatic logic [3:0] to_p1of4(input logic [1:0] val);
        return 4'b0001 << val;
    endfunction

endpackage

// File: rtl/p1of4_encoder.sv
// Combinational 1-of-4 encoder: each 2-bit group of data_i becomes one
// 4-bit one-hot group of enc_c.
//   data_i : WIDTH-bit single-rail value (WIDTH must be even)
//   enc_c  : 2*WIDTH-bit encoded value, group g in enc_c[4g+3:4g]
module p1of4_encoder
    import csp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   data_i,
    output logic [2*WIDTH-1:0] enc_c
);

    localparam int unsigned GROUPS = WIDTH / 2;

    if ((WIDTH % 2) != 0) begin : g_width_chk
        $error("p1of4_encoder: WIDTH must be even");
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        assign enc_c[4*g +: 4] = to_p1of4(data_i[2*g +: 2]);
    end

endmodule

// File: rtl/csp_channel.sv
// Unbuffered CSP rendezvous channel between one sender and one receiver.
// Data moves on the clock edge where both requests have been seen; both
// sides then get a one-cycle done pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   snd_req     : sender request (level), snd_data value to send
//   snd_done    : one-cycle pulse, send completed
//   rcv_req     : receiver request (level)
//   rcv_done    : one-cycle pulse, receive completed, rcv_data valid
//   rcv_data    : last transferred value
//   p1of4_data  : 1-of-4 encoding of rcv_data (all zero = spacer after reset)
//   p1of4_vld   : set once any transfer has completed since reset
//   xfer_count  : completed transfers, wraps
module csp_channel
    import csp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snd_req,
    input  logic [WIDTH-1:0]   snd_data,
    output logic               snd_done,
    input  logic               rcv_req,
    output logic               rcv_done,
    output logic [WIDTH-1:0]   rcv_data,
    output logic [2*WIDTH-1:0] p1of4_data,
    output logic               p1of4_vld,
    output logic [CNT_W-1:0]   xfer_count
);

    chan_state_t        state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   rcv_data_q, rcv_data_d;
    logic [2*WIDTH-1:0] p1of4_q, p1of4_d;
    logic [2*WIDTH-1:0] enc_c;
    logic               vld_q, vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer_c;

    p1of4_encoder #(.WIDTH(WIDTH)) u_enc (
        .data_i (snd_data),
        .enc_c  (enc_c)
    );

    // Rendezvous FSM; a request dropped while waiting abandons the rendezvous.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (snd_req && rcv_req) state_d = DONE;
                else if (snd_req)       state_d = SND_WAIT;
                else if (rcv_req)       state_d = RCV_WAIT;
            end
            SND_WAIT: begin
                if (!snd_req)     state_d = IDLE;
                else if (rcv_req) state_d = DONE;
            end
            RCV_WAIT: begin
                if (!rcv_req)     state_d = IDLE;
                else if (snd_req) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DONE always exits next cycle, so entering it is the transfer edge.
    always_comb begin
        xfer_c     = (state_d == DONE);
        done_d     = xfer_c;
        rcv_data_d = rcv_data_q;
        p1of4_d    = p1of4_q;
        vld_d      = vld_q;
        cnt_d      = cnt_q;
        if (xfer_c) begin
            rcv_data_d = snd_data;
            p1of4_d    = enc_c;
            vld_d      = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            rcv_data_q <= '0;
            p1of4_q    <= '0;
            vld_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            rcv_data_q <= rcv_data_d;
            p1of4_q    <= p1of4_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign snd_done   = done_q;
    assign rcv_done   = done_q;
    assign rcv_data   = rcv_data_q;
    assign p1of4_data = p1of4_q;
    assign p1of4_vld  = vld_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_csp_channel.sv
// Scoreboard bench for csp_channel: a default-width instance for the main
// scenarios and a CNT_W=4 instance for counter wrap.
module tb_csp_channel;

    localparam int unsigned W   = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            snd_req = 1'b0, rcv_req = 1'b0;
    logic [W-1:0]    snd_data = '0;
    logic            snd_done, rcv_done, p1of4_vld;
    logic [W-1:0]    rcv_data;
    logic [2*W-1:0]  p1of4_data;
    logic [CW-1:0]   xfer_count;

    logic            snd_req2 = 1'b0, rcv_req2 = 1'b0;
    logic [W-1:0]    snd_data2 = '0;
    logic            snd_done2, rcv_done2, p1of4_vld2;
    logic [W-1:0]    rcv_data2;
    logic [2*W-1:0]  p1of4_data2;
    logic [CW2-1:0]  xfer_count2;

    csp_channel #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .snd_req(snd_req), .snd_data(snd_data), .snd_done(snd_done),
        .rcv_req(rcv_req), .rcv_done(rcv_done), .rcv_data(rcv_data),
        .p1of4_data(p1of4_data), .p1of4_vld(p1of4_vld), .xfer_count(xfer_count)
    );

    csp_channel #(.WIDTH(W), .CNT_W(CW2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .snd_req(snd_req2), .snd_data(snd_data2), .snd_done(snd_done2),
        .rcv_req(rcv_req2), .rcv_done(rcv_done2), .rcv_data(rcv_data2),
        .p1of4_data(p1of4_data2), .p1of4_vld(p1of4_vld2), .xfer_count(xfer_count2)
    );

    typedef struct {
        logic [W-1:0]   d;
        logic [2*W-1:0] p;
        logic [CW-1:0]  c;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [CW-1:0] exp_cnt = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Reference encoding: set bit (4*g + group value) for every 2-bit group.
    function automatic logic [2*W-1:0] model_p1of4(input logic [W-1:0] d);
        logic [2*W-1:0] r;
        r = '0;
        for (int g = 0; g < W/2; g++) r[4*g + int'(d[2*g +: 2])] = 1'b1;
        return r;
    endfunction

    task automatic push_exp(input logic [W-1:0] d, input int unsigned cw);
        exp_cnt = exp_cnt + 16'd1;
        if (cw == CW2) exp_cnt = exp_cnt & 16'h000F;
        sb.push_back('{d: d, p: model_p1of4(d), c: exp_cnt});
    endtask

    // Advance negedges until done is seen on the chosen instance (bounded).
    task automatic wait_done(input bit inst2, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(inst2 ? snd_done2 : snd_done) && lat < 20);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({snd_done, rcv_done, rcv_data, p1of4_data, p1of4_vld, xfer_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: outs=%h required 0",
                     {snd_done, rcv_done, rcv_data, p1of4_data, p1of4_vld, xfer_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_sender_first();
        int lat;
        snd_req = 1'b1; snd_data = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (snd_done !== 1'b0 || rcv_done !== 1'b0) begin
                n_bad++;
                $display("FAIL sf_wait_done: cyc %0d done=%b/%b required 0/0", i, snd_done, rcv_done);
            end
        end
        rcv_req = 1'b1;
        push_exp(8'h01, CW);
        wait_done(1'b0, lat);
        n_cmp++;
        if (lat != 1 || rcv_done !== 1'b1) begin
            n_bad++;
            $display("FAIL sf_latency: lat=%0d rcv_done=%b required 1/1", lat, rcv_done);
        end
        e = sb.pop_front();
        n_cmp++;
        if (rcv_data !== e.d || p1of4_data !== e.p || xfer_count !== e.c || p1of4_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL sf_data: d=%h p=%h c=%0d v=%b required %h %h %0d 1",
                     rcv_data, p1of4_data, xfer_count, p1of4_vld, e.d, e.p, e.c);
        end
        n_cmp++;
        if (p1of4_data !== 16'h1112) begin
            n_bad++;
            $display("FAIL sf_p1of4_const: p=%h required 1112", p1of4_data);
        end
        snd_req = 1'b0; rcv_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (snd_done !== 1'b0 || rcv_done !== 1'b0) begin
            n_bad++;
            $display("FAIL sf_pulse_width: done=%b/%b required 0/0", snd_done, rcv_done);
        end
    endtask

    task automatic test_receiver_first();
        int lat;
        rcv_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rcv_done !== 1'b0 || rcv_data !== 8'h01) begin
                n_bad++;
                $display("FAIL rf_wait: cyc %0d done=%b d=%h required 0 01", i, rcv_done, rcv_data);
            end
        end
        snd_req = 1'b1; snd_data = 8'h00;
        push_exp(8'h00, CW);
        wait_done(1'b0, lat);
        n_cmp++;
        if (lat != 1) begin
            n_bad++;
            $display("FAIL rf_latency: lat=%0d required 1", lat);
        end
        e = sb.pop_front();
        n_cmp++;
        if (rcv_data !== e.d || p1of4_data !== e.p || xfer_count !== e.c || p1of4_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL rf_data: d=%h p=%h c=%0d v=%b required %h %h %0d 1",
                     rcv_data, p1of4_data, xfer_count, p1of4_vld, e.d, e.p, e.c);
        end
        snd_req = 1'b0; rcv_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals[2];
        int lat;
        vals[0] = 8'hB4; vals[1] = 8'hFF;
        snd_req = 1'b1; rcv_req = 1'b1; snd_data = vals[0];
        push_exp(vals[0], CW);
        for (int k = 0; k < 2; k++) begin
            wait_done(1'b0, lat);
            n_cmp++;
            if (lat != (k == 0 ? 1 : 2)) begin
                n_bad++;
                $display("FAIL b2b_spacing: xfer %0d lat=%0d required %0d", k, lat, (k == 0 ? 1 : 2));
            end
            e = sb.pop_front();
            n_cmp++;
            if (rcv_data !== e.d || p1of4_data !== e.p || xfer_count !== e.c) begin
                n_bad++;
                $display("FAIL b2b_data: xfer %0d d=%h p=%h c=%0d required %h %h %0d",
                         k, rcv_data, p1of4_data, xfer_count, e.d, e.p, e.c);
            end
            if (k == 0) begin
                snd_data = vals[1];
                push_exp(vals[1], CW);
            end
        end
        n_cmp++;
        if (p1of4_data !== 16'h8888 || xfer_count !== 16'd4) begin
            n_bad++;
            $display("FAIL b2b_final: p=%h c=%0d required 8888 4", p1of4_data, xfer_count);
        end
        snd_req = 1'b0; rcv_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_snd_wait();
        snd_req = 1'b1; snd_data = 8'h5A;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({snd_done, rcv_data, p1of4_data, p1of4_vld, xfer_count} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: outs=%h required 0",
                     {snd_done, rcv_data, p1of4_data, p1of4_vld, xfer_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        snd_req = 1'b0;
        exp_cnt = '0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (snd_done !== 1'b0 || xfer_count !== 16'd0) begin
                n_bad++;
                $display("FAIL rst_lost: cyc %0d done=%b c=%0d required 0 0", i, snd_done, xfer_count);
            end
        end
    endtask

    task automatic test_withdraw();
        int lat;
        snd_req = 1'b1; snd_data = 8'h77;
        repeat (2) @(negedge clk);
        snd_req = 1'b0;
        @(negedge clk);
        rcv_req = 1'b1;
        repeat (2) @(negedge clk);
        rcv_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (snd_done !== 1'b0 || xfer_count !== 16'd0 || rcv_data !== 8'h00 || p1of4_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw: done=%b c=%0d d=%h v=%b required 0 0 00 0",
                     snd_done, xfer_count, rcv_data, p1of4_vld);
        end
        snd_req = 1'b1; rcv_req = 1'b1; snd_data = 8'hC3;
        push_exp(8'hC3, CW);
        wait_done(1'b0, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat != 1 || rcv_data !== e.d || p1of4_data !== e.p || xfer_count !== e.c) begin
            n_bad++;
            $display("FAIL withdraw_recover: lat=%0d d=%h p=%h c=%0d required 1 %h %h %0d",
                     lat, rcv_data, p1of4_data, xfer_count, e.d, e.p, e.c);
        end
        snd_req = 1'b0; rcv_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rcv_data !== 8'hC3 || p1of4_data !== model_p1of4(8'hC3) || p1of4_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL hold: d=%h p=%h v=%b required c3 %h 1",
                     rcv_data, p1of4_data, p1of4_vld, model_p1of4(8'hC3));
        end
    endtask

    task automatic test_counter_wrap();
        int lat;
        logic [W-1:0] d;
        exp_cnt = '0;
        sb.delete();
        d = W'($urandom_range(0, 255));
        snd_req2 = 1'b1; rcv_req2 = 1'b1; snd_data2 = d;
        push_exp(d, CW2);
        for (int k = 0; k < 17; k++) begin
            wait_done(1'b1, lat);
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wrap_sb_empty: xfer %0d", k);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (lat > 2 || rcv_data2 !== e.d || p1of4_data2 !== e.p || xfer_count2 !== CW2'(e.c)) begin
                    n_bad++;
                    $display("FAIL wrap_xfer: %0d lat=%0d d=%h p=%h c=%0d required %h %h %0d",
                             k, lat, rcv_data2, p1of4_data2, xfer_count2, e.d, e.p, e.c);
                end
            end
            if (k < 16) begin
                d = W'($urandom_range(0, 255));
                snd_data2 = d;
                push_exp(d, CW2);
            end
        end
        snd_req2 = 1'b0; rcv_req2 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (xfer_count2 !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap_final: c=%0d required 1", xfer_count2);
        end
    endtask

    initial begin
        test_reset();
        test_sender_first();
        test_receiver_first();
        test_back_to_back();
        test_reset_in_snd_wait();
        test_withdraw();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
